// File: rtl/afifo_pkg.sv
// Shared async-FIFO helpers: default depth, gray->binary decode and a popcount
// used by the gray-step checker.
package afifo_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int DEPTH         = 2**ADDR_SIZE_DEF;
  localparam int MAXW          = 32;

  // Works for any width up to MAXW: zero-extended upper gray bits decode to 0,
  // so callers extend their operand and slice the result back down.
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAXW; i++)
      n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Plain N-flop pointer synchroniser; reused by the read side with its own clock.
module sync_r2w #(
  parameter int ADDR_SIZE   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic [ADDR_SIZE:0]   d,
  output logic [ADDR_SIZE:0]   q
);

  logic [SYNC_STAGES-1:0][ADDR_SIZE:0] stg;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/wrptr_level.sv
// Write-domain receiver for the gray read pointer: sync, decode, fill level,
// almost-full, and sticky checkers for illegal level / multi-bit gray steps.
module wrptr_level
  import afifo_pkg::*;
#(
  parameter int ADDR_SIZE   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [ADDR_SIZE:0] rptr,
  input  logic [ADDR_SIZE:0] wptr,
  input  logic [ADDR_SIZE:0] afull_thresh,
  output logic [ADDR_SIZE:0] wq2_rptr,
  output logic [ADDR_SIZE:0] wq2_rbin,
  output logic [ADDR_SIZE:0] wfill,
  output logic               walmost_full,
  output logic               werr_level,
  output logic               werr_gray
);

  localparam int AW = ADDR_SIZE + 1;
  localparam logic [AW-1:0] FILL_MAX = AW'(2**ADDR_SIZE);

  logic [AW-1:0] rbin_q, wbin_q, prev_q;
  logic          gray_jump;

  sync_r2w #(.ADDR_SIZE(ADDR_SIZE), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d      (rptr),
    .q      (wq2_rptr)
  );

  assign gray_jump = popcount(MAXW'(wq2_rptr ^ prev_q)) > 1;

  // Pointer difference is taken modulo 2**AW, which absorbs the pointer wrap.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rbin_q       <= '0;
      wbin_q       <= '0;
      prev_q       <= '0;
      wfill        <= '0;
      walmost_full <= 1'b0;
      werr_level   <= 1'b0;
      werr_gray    <= 1'b0;
    end else begin
      rbin_q       <= AW'(gray2bin(MAXW'(wq2_rptr)));
      wbin_q       <= AW'(gray2bin(MAXW'(wptr)));
      prev_q       <= wq2_rptr;
      wfill        <= wbin_q - rbin_q;
      walmost_full <= (afull_thresh != '0) && (wfill >= afull_thresh);
      werr_level   <= werr_level | (wfill > FILL_MAX);
      werr_gray    <= werr_gray | gray_jump;
    end
  end

  assign wq2_rbin = rbin_q;

endmodule

// File: tb/tb_wrptr_level.sv
module tb_wrptr_level;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic [4:0] rptr, wptr, afull_thresh;
  logic [4:0] wq2_rptr, wq2_rbin, wfill;
  logic       walmost_full, werr_level, werr_gray;

  wrptr_level #(.ADDR_SIZE(4), .SYNC_STAGES(2)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .rptr         (rptr),
    .wptr         (wptr),
    .afull_thresh (afull_thresh),
    .wq2_rptr     (wq2_rptr),
    .wq2_rbin     (wq2_rbin),
    .wfill        (wfill),
    .walmost_full (walmost_full),
    .werr_level   (werr_level),
    .werr_gray    (werr_gray)
  );

  always #5 wclk = ~wclk;

  int cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  localparam int S_WQ2R = 0, S_WQ2B = 1, S_FILL = 2, S_AF = 3, S_ELV = 4, S_EGR = 5;

  typedef struct {
    int          due;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_WQ2R:  return {27'd0, wq2_rptr};
      S_WQ2B:  return {27'd0, wq2_rbin};
      S_FILL:  return {27'd0, wfill};
      S_AF:    return {31'd0, walmost_full};
      S_ELV:   return {31'd0, werr_level};
      default: return {31'd0, werr_gray};
    endcase
  endfunction

  task automatic expect_at(input int k, input int sig, input logic [31:0] val, input string nm);
    exp_t e;
    e.due  = cyc + k;
    e.sig  = sig;
    e.val  = val;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input int k, input string nm);
    for (int s = 0; s <= S_EGR; s++) expect_at(k, s, 32'd0, nm);
  endtask

  task automatic tick();
    @(negedge wclk);
    #1;
  endtask

  always begin
    @(negedge wclk);
    #3;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due <= cyc) begin
        logic [31:0] a;
        a = actual(sb[i].sig);
        checks++;
        if (a !== sb[i].val) begin
          errors++;
          $display("FAIL %s sig=%0d cyc=%0d got=%0d exp=%0d",
                   sb[i].name, sb[i].sig, cyc, a, sb[i].val);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  initial begin
    wrst_n = 1'b0; rptr = '0; wptr = '0; afull_thresh = 5'd12;
    tick();
    expect_all_zero(0, "por_zero");
    tick();
    wrst_n = 1'b1;
    tick();

    rptr = 5'b10001; wptr = 5'b00011;
    expect_at(2, S_WQ2R, 32'd17, "wrap_wq2_rptr");
    expect_at(2, S_WQ2B, 32'd0,  "wrap_rbin_early");
    expect_at(3, S_WQ2B, 32'd30, "wrap_rbin");
    expect_at(2, S_FILL, 32'd2,  "wrap_fill_pre");
    expect_at(3, S_FILL, 32'd2,  "wrap_fill_pre2");
    expect_at(4, S_FILL, 32'd4,  "wrap_fill");
    repeat (6) tick();

    wrst_n = 1'b0;
    #1;
    checks++;
    if ({wq2_rptr, wq2_rbin, wfill, walmost_full, werr_level, werr_gray} !== 18'd0) begin
      errors++;
      $display("FAIL rst_direct: outputs not cleared asynchronously");
    end
    expect_all_zero(0, "rst_async");
    tick();
    expect_all_zero(0, "rst_hold1");
    tick();
    expect_all_zero(0, "rst_hold2");
    rptr = '0; wptr = '0; afull_thresh = 5'd12;
    tick();
    wrst_n = 1'b1;
    tick();

    for (int i = 0; i <= 16; i++) begin
      wptr = 5'(i ^ (i >> 1));
      expect_at(2, S_FILL, i, "ramp_fill");
      expect_at(3, S_AF, (i >= 12) ? 32'd1 : 32'd0, "ramp_afull");
      expect_at(3, S_ELV, 32'd0, "ramp_errlvl");
      tick();
    end
    repeat (3) tick();
    expect_at(0, S_FILL, 32'd16, "ramp_top");

    afull_thresh = 5'd0;
    expect_at(1, S_AF, 32'd0, "thr_off1");
    expect_at(2, S_AF, 32'd0, "thr_off2");
    tick();
    tick();
    afull_thresh = 5'd16;
    expect_at(1, S_AF, 32'd1, "thr_16");
    tick();
    tick();

    wptr = 5'b11001;
    expect_at(2, S_FILL, 32'd17, "lvl_fill17");
    expect_at(2, S_ELV,  32'd0,  "lvl_pre");
    expect_at(3, S_ELV,  32'd1,  "lvl_set");
    tick();
    wptr = 5'b00000;
    expect_at(2, S_FILL, 32'd0, "lvl_fill0");
    expect_at(3, S_ELV,  32'd1, "lvl_sticky");
    expect_at(6, S_ELV,  32'd1, "lvl_sticky2");
    repeat (6) tick();

    rptr = 5'b00001;
    expect_at(2, S_WQ2R, 32'd1, "gray_legal_sync");
    expect_at(3, S_WQ2B, 32'd1, "gray_legal_rbin");
    expect_at(3, S_EGR,  32'd0, "gray_legal");
    expect_at(5, S_EGR,  32'd0, "gray_legal2");
    repeat (5) tick();
    rptr = 5'b00000;
    expect_at(3, S_EGR, 32'd0, "gray_legal_back");
    repeat (5) tick();
    rptr = 5'b00011;
    expect_at(2, S_EGR,  32'd0,  "gray_pre");
    expect_at(3, S_EGR,  32'd1,  "gray_set");
    expect_at(8, S_EGR,  32'd1,  "gray_sticky");
    expect_at(3, S_WQ2B, 32'd2,  "gray_rbin");
    expect_at(4, S_FILL, 32'd30, "gray_fill_mod");
    repeat (9) tick();

    checks++;
    if (werr_gray !== 1'b1 || werr_level !== 1'b1) begin
      errors++;
      $display("FAIL sticky_direct: werr_gray=%0b werr_level=%0b", werr_gray, werr_level);
    end

    for (int t = 0; t < 20 && sb.size() != 0; t++) tick();
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s sig=%0d never checked (due=%0d)", sb[i].name, sb[i].sig, sb[i].due);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrptr_level.md
Name: wrptr_level

Overview:
- Write-clock-domain receiver for the gray-coded read pointer of the async FIFO.
- Synchronises the read pointer into wclk and hands the synchronised gray value to the write-pointer/full logic.
- Decodes both pointers gray->binary and produces a registered fill level and a programmable almost-full flag.
- Acts as a checker: sticky flags for an illegal fill level and for a multi-bit gray step.

Parameters:
- ADDR_SIZE, 4, FIFO address width; DEPTH = 2**ADDR_SIZE.
- SYNC_STAGES, 2, synchroniser flops for rptr; legal values 2..4.

Ports:
- wclk  in  1  write clock
- wrst_n  in  1  reset
- rptr  in  ADDR_SIZE+1  read pointer, gray, rclk domain
- wptr  in  ADDR_SIZE+1  write pointer, gray, wclk domain
- afull_thresh  in  ADDR_SIZE+1  almost-full threshold; 0 = disabled
- wq2_rptr  out  ADDR_SIZE+1  synchronised read pointer, gray
- wq2_rbin  out  ADDR_SIZE+1  synchronised read pointer, binary
- wfill  out  ADDR_SIZE+1  fill level, 0..DEPTH
- walmost_full  out  1  fill level >= threshold
- werr_level  out  1  sticky: fill level exceeded DEPTH
- werr_gray  out  1  sticky: synchronised rptr changed more than 1 bit between samples

Behaviour:
- Reset: wrst_n is asynchronous, active-low; clock is wclk. While wrst_n = 0, all flops and all outputs are 0, with no clock edge required.
- Sync chain:
  - rptr passes through SYNC_STAGES flops; wq2_rptr is the last stage.
  - An rptr change is visible on wq2_rptr after SYNC_STAGES wclk edges.
- Decode stage (registered):
  - rbin_q <= gray2bin(wq2_rptr); wbin_q <= gray2bin(wptr).
  - wq2_rbin = rbin_q, so it updates at edge SYNC_STAGES+1 after an rptr change.
  - gray2bin: bin[MSB] = g[MSB]; bin[i] = bin[i+1] ^ g[i].
- Fill stage (registered):
  - wfill <= (wbin_q - rbin_q) modulo 2**(ADDR_SIZE+1), computed at full ADDR_SIZE+1 width. The wrap from 2**(ADDR_SIZE+1)-1 to 0 is handled by this modulo arithmetic; there is no special case.
  - Latency: 2 edges from wptr, SYNC_STAGES+2 edges from rptr.
- Almost-full (registered, one edge after wfill):
  - walmost_full <= (afull_thresh != 0) && (wfill >= afull_thresh).
  - afull_thresh > DEPTH keeps the flag low unless the fill level is illegal.
  - afull_thresh is quasi-static; a change takes effect on the next edge.
- werr_level: set on the edge after wfill > DEPTH; holds until reset.
- werr_gray:
  - prev_q <= wq2_rptr every edge.
  - werr_gray <= werr_gray | (popcount(wq2_rptr ^ prev_q) > 1).
  - Asserts SYNC_STAGES+1 edges after the offending rptr change; holds until reset.
- Simultaneous wptr and rptr changes: each travels its own latency; wfill can transiently over-report by the read-side lag. This is the intended pessimistic direction for the write side.
- Reset mid-operation clears the sticky flags and the sync chain. The first post-reset wfill reflects the pointers 2 edges after release; the rptr term has its extra sync lag.
- No handshakes; outputs update every cycle.

Decomposition:
- Package afifo_pkg:
  - localparam DEPTH.
  - function gray2bin, parameterised by width.
  - function popcount (used by the gray checker).
- Sub-module sync_r2w (ADDR_SIZE, SYNC_STAGES): pure N-flop synchroniser with async reset. It is reusable by the read side with its own clock/reset. Everything else stays in wrptr_level.

Test Plan (ADDR_SIZE=4, SYNC_STAGES=2):
- Reset: drive rptr=5'b10001, wptr=5'b00011, assert wrst_n=0 between edges -> all outputs 0 immediately; they stay 0 while reset is held.
- Fill count, rptr=0, afull_thresh=12:
  - Step wptr through gray(0..16), one value per edge -> wfill follows 2 edges behind and reaches 16 (wptr=5'b11000).
  - walmost_full rises the edge after wfill=12.
  - werr_level stays 0.
- Wrap-around: rptr=gray(30)=5'b10001, wptr=gray(2)=5'b00011 -> wq2_rbin=30 after 3 edges; wfill=4 after 4 edges.
- Level error, rptr=0:
  - wptr=gray(17)=5'b11001 -> wfill=17, werr_level=1 the next edge.
  - Return wptr=0 -> wfill=0, werr_level stays 1.
- Gray error: rptr 5'b00000 -> 5'b00011 in one step -> werr_gray=1 three edges later and sticky. A legal single-bit step 5'b00000 -> 5'b00001 leaves it 0.
- Threshold disabled: afull_thresh=0, wfill=16 -> walmost_full stays 0; setting afull_thresh=16 -> walmost_full=1 on the next edge.
